// File: rtl/jcs_pkg.sv
// Shared definitions for the jcscpu bus-transfer sequencer: register codes,
// phase states and the request legality check.
package jcs_pkg;

   localparam logic [3:0] DATA = 4'd1;
   localparam logic [3:0] R0   = 4'd2;
   localparam logic [3:0] R1   = 4'd3;
   localparam logic [3:0] R2   = 4'd4;
   localparam logic [3:0] R3   = 4'd5;
   localparam logic [3:0] TMP  = 4'd6;
   localparam logic [3:0] ACC  = 4'd7;
   localparam logic [3:0] MAR  = 4'd8;
   localparam logic [3:0] RAM  = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EN   = 2'd1,
      ST   = 2'd2,
      HD   = 2'd3
   } phase_e;

   // Both codes inside [first, last] and not a self-transfer.
   function automatic logic is_legal(input logic [3:0] i_src, input logic [3:0] i_dst,
                                     input logic [3:0] i_first, input logic [3:0] i_last);
      return (i_src >= i_first) && (i_src <= i_last) &&
             (i_dst >= i_first) && (i_dst <= i_last) &&
             (i_src != i_dst);
   endfunction

endpackage

// File: rtl/jcs_onehot4x16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module jcs_onehot4x16 (
   input  logic        i_en,
   input  logic [3:0]  i_code,
   output logic [15:0] o_onehot
);

   assign o_onehot = i_en ? (16'h0001 << i_code) : 16'h0000;

endmodule

// File: rtl/jcs_bus_xfer.sv
// Bus-transfer sequencer: drives enable, enable+set, enable-hold strobes for one
// (SRC, DST) request. Define JCS_XFER_ERR_EN to get a sticky illegal-request flag on ERR.
module jcs_bus_xfer
   import jcs_pkg::*;
#(
   parameter int         PHASE_CYCLES = 1,
   parameter logic [3:0] FIRST        = DATA,
   parameter logic [3:0] LAST         = RAM
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        REQ,
   input  logic [3:0]  SRC,
   input  logic [3:0]  DST,
   output logic        READY,
   output logic [15:0] ENA_DEC,
   output logic [15:0] SET_DEC,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output phase_e      o_dbg_state
);

   localparam logic [3:0] L_RELOAD = 4'(PHASE_CYCLES - 1);

   phase_e      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [3:0]  r_src, w_src_nxt;
   logic [3:0]  r_dst, w_dst_nxt;
   logic        r_ready, r_busy, r_done;
   logic [15:0] r_ena, r_set;
   logic [15:0] w_ena_nxt, w_set_nxt;
   logic        w_legal, w_accept, w_ena_en, w_set_en;

   assign w_legal  = is_legal(SRC, DST, FIRST, LAST);
   // r_ready stays low for the first cycle after reset release.
   assign w_accept = REQ && r_ready && w_legal;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      if (r_state == IDLE) begin
         if (w_accept) begin
            w_state_nxt = EN;
            w_cnt_nxt   = L_RELOAD;
            w_src_nxt   = SRC;
            w_dst_nxt   = DST;
         end
      end else if (r_cnt != 4'd0) begin
         w_cnt_nxt = r_cnt - 4'd1;
      end else begin
         w_cnt_nxt = L_RELOAD;
         case (r_state)
            EN:      w_state_nxt = ST;
            ST:      w_state_nxt = HD;
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // Strobes are decoded from the next state so the registered outputs line up with it.
   assign w_ena_en = (w_state_nxt != IDLE);
   assign w_set_en = (w_state_nxt == ST);

   jcs_onehot4x16 u_ena_dec (
      .i_en     (w_ena_en),
      .i_code   (w_src_nxt),
      .o_onehot (w_ena_nxt)
   );

   jcs_onehot4x16 u_set_dec (
      .i_en     (w_set_en),
      .i_code   (w_dst_nxt),
      .o_onehot (w_set_nxt)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_src   <= 4'd0;
         r_dst   <= 4'd0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ena   <= 16'h0000;
         r_set   <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_ready <= (w_state_nxt == IDLE);
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (r_state == HD) && (r_cnt == 4'd0);
         r_ena   <= w_ena_nxt;
         r_set   <= w_set_nxt;
      end
   end

`ifdef JCS_XFER_ERR_EN
   logic r_err;
   logic w_reject;

   assign w_reject = REQ && r_ready && !w_legal;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_reject) begin
         r_err <= 1'b1;
      end
   end

   assign ERR = r_err;
`else
   assign ERR = 1'b0;
`endif

   assign READY       = r_ready;
   assign BUSY        = r_busy;
   assign DONE        = r_done;
   assign ENA_DEC     = r_ena;
   assign SET_DEC     = r_set;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jcs_bus_xfer.sv
// Bench for jcs_bus_xfer: two instances (PHASE_CYCLES=1 and 4) share one stimulus stream;
// a cycle-index model predicts every output each cycle, plus directed literal checks.
module tb_jcs_bus_xfer;
   import jcs_pkg::*;

`ifdef JCS_XFER_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        req   = 1'b0;
   logic [3:0]  src   = 4'd0;
   logic [3:0]  dst   = 4'd0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;

   logic        ready1, busy1, done1, err1;
   logic [15:0] ena1, set1;
   phase_e      st1;
   logic        ready4, busy4, done4, err4;
   logic [15:0] ena4, set4;
   phase_e      st4;

   jcs_bus_xfer #(.PHASE_CYCLES(1)) dut1 (
      .CLK(clk), .RSTN(rst_n), .REQ(req), .SRC(src), .DST(dst),
      .READY(ready1), .ENA_DEC(ena1), .SET_DEC(set1), .BUSY(busy1),
      .DONE(done1), .ERR(err1), .o_dbg_state(st1)
   );

   jcs_bus_xfer #(.PHASE_CYCLES(4)) dut4 (
      .CLK(clk), .RSTN(rst_n), .REQ(req), .SRC(src), .DST(dst),
      .READY(ready4), .ENA_DEC(ena4), .SET_DEC(set4), .BUSY(busy4),
      .DONE(done4), .ERR(err4), .o_dbg_state(st4)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_k = cycle index within a transfer (1..3P), 0 when idle.
   int         m_p[2] = '{1, 4};
   int         m_k[2];
   logic [3:0] m_src[2], m_dst[2];
   bit         m_rdy[2], m_done[2], m_err[2];

   function automatic bit legal(input logic [3:0] s, input logic [3:0] d);
      return (s >= 4'd1) && (s <= 4'd9) && (d >= 4'd1) && (d <= 4'd9) && (s != d);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_k[d] = 0; m_rdy[d] = 1'b0; m_done[d] = 1'b0; m_err[d] = 1'b0;
            m_src[d] = 4'd0; m_dst[d] = 4'd0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            bit acc, rej;
            acc = m_rdy[d] && req && legal(src, dst);
            rej = m_rdy[d] && req && !legal(src, dst);
            m_done[d] = (m_k[d] == 3 * m_p[d]);
            if (acc) begin
               m_k[d] = 1; m_src[d] = src; m_dst[d] = dst;
            end else if (m_k[d] != 0 && m_k[d] < 3 * m_p[d]) begin
               m_k[d]++;
            end else begin
               m_k[d] = 0;
            end
            m_rdy[d] = (m_k[d] == 0);
            if (ERR_ON) begin
               if (acc)      m_err[d] = 1'b0;
               else if (rej) m_err[d] = 1'b1;
            end
         end
      end
   end

   function automatic logic [15:0] exp_ena(input int d);
      return (m_k[d] != 0) ? (16'h0001 << m_src[d]) : 16'h0000;
   endfunction

   function automatic logic [15:0] exp_set(input int d);
      return (m_k[d] > m_p[d] && m_k[d] <= 2 * m_p[d]) ? (16'h0001 << m_dst[d]) : 16'h0000;
   endfunction

   function automatic logic [1:0] exp_state(input int d);
      if (m_k[d] == 0)           return 2'd0;
      if (m_k[d] <= m_p[d])      return 2'd1;
      if (m_k[d] <= 2 * m_p[d])  return 2'd2;
      return 2'd3;
   endfunction

   task automatic compare_dut(input int d, input string tag, input logic rdy, input logic [15:0] ena,
                              input logic [15:0] set, input logic bsy, input logic dn,
                              input logic er, input phase_e st);
      check({tag, " READY"}, 32'(rdy), 32'(m_rdy[d]));
      check({tag, " ENA_DEC"}, 32'(ena), 32'(exp_ena(d)));
      check({tag, " SET_DEC"}, 32'(set), 32'(exp_set(d)));
      check({tag, " BUSY"}, 32'(bsy), 32'(m_k[d] != 0));
      check({tag, " DONE"}, 32'(dn), 32'(m_done[d]));
      check({tag, " ERR"}, 32'(er), 32'(m_err[d]));
      check({tag, " STATE"}, 32'(st), 32'(exp_state(d)));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         compare_dut(0, "p1", ready1, ena1, set1, busy1, done1, err1, st1);
         compare_dut(1, "p4", ready4, ena4, set4, busy4, done4, err4, st4);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n;
      n = 0;
      while (!(ready1 && ready4 && !busy1 && !busy4) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_cmp++;
         n_mis++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
      end
      @(negedge clk);
   endtask

   // Drives REQ for one cycle starting at the current negedge.
   task automatic pulse_req(input logic [3:0] s, input logic [3:0] d);
      req = 1'b1; src = s; dst = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   logic [15:0] t_ena[8];
   logic [15:0] t_set[8];
   logic        t_done[8];
   logic [3:0]  ill_src[3];
   logic [3:0]  ill_dst[3];

   initial begin
      #2 rst_n = 1'b0;
      #1 chk_on = 1'b1;

      // Reset / idle
      @(negedge clk);
      check("rst READY low", 32'(ready1), 32'h0);
      check("rst ENA_DEC", 32'(ena1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst READY", 32'(ready1), 32'h1);
      check("post-rst DONE", 32'(done1), 32'h0);

      // Basic transfer DATA -> R0, PHASE_CYCLES=1
      req = 1'b1; src = DATA; dst = R0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) req = 1'b0;
         check($sformatf("basic ENA c%0d", c), 32'(ena1), (c <= 3) ? 32'h0002 : 32'h0);
         check($sformatf("basic SET c%0d", c), 32'(set1), (c == 2) ? 32'h0004 : 32'h0);
         check($sformatf("basic DONE c%0d", c), 32'(done1), (c == 4) ? 32'h1 : 32'h0);
      end
      wait_idle();

      // Stretched phases ACC -> RAM, PHASE_CYCLES=4
      req = 1'b1; src = ACC; dst = RAM;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) req = 1'b0;
         check($sformatf("p4 ENA c%0d", c), 32'(ena4), (c <= 12) ? 32'h0080 : 32'h0);
         check($sformatf("p4 SET c%0d", c), 32'(set4), (c >= 5 && c <= 8) ? 32'h0200 : 32'h0);
         check($sformatf("p4 DONE c%0d", c), 32'(done4), (c == 13) ? 32'h1 : 32'h0);
      end
      wait_idle();

      // Back-to-back with REQ held: R0->R1 then R1->R2
      t_ena  = '{16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0008, 16'h0008, 16'h0008, 16'h0000};
      t_set  = '{16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000};
      t_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      req = 1'b1; src = R0; dst = R1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin src = R1; dst = R2; end
         check($sformatf("b2b ENA c%0d", c), 32'(ena1), 32'(t_ena[c-1]));
         check($sformatf("b2b SET c%0d", c), 32'(set1), 32'(t_set[c-1]));
         check($sformatf("b2b DONE c%0d", c), 32'(done1), 32'(t_done[c-1]));
         if (c == 8) req = 1'b0;
      end
      wait_idle();

      // Illegal requests are dropped
      ill_src = '{4'd5, 4'd0, 4'd10};
      ill_dst = '{4'd5, 4'd2, 4'd3};
      for (int i = 0; i < 3; i++) begin
         pulse_req(ill_src[i], ill_dst[i]);
         @(negedge clk);
         check($sformatf("ill%0d READY", i), 32'(ready1), 32'h1);
         check($sformatf("ill%0d ENA_DEC", i), 32'(ena1), 32'h0);
         check($sformatf("ill%0d ERR", i), 32'(err1), 32'(ERR_ON));
      end
      pulse_req(DATA, R1);
      check("legal-after-ill ERR", 32'(err1), 32'h0);
      check("legal-after-ill ENA", 32'(ena1), 32'h0002);
      wait_idle();

      // REQ while busy is ignored
      pulse_req(R0, R3);
      check("busy-req SET c2 pre", 32'(set1), 32'h0);
      req = 1'b1; src = R2; dst = TMP;
      @(negedge clk);
      req = 1'b0;
      check("busy-req SET c2", 32'(set1), 32'h0020);
      @(negedge clk);
      check("busy-req ENA c3", 32'(ena1), 32'h0004);
      check("busy-req SET c3", 32'(set1), 32'h0);
      @(negedge clk);
      check("busy-req DONE c4", 32'(done1), 32'h1);
      @(negedge clk);
      check("busy-req DONE c5", 32'(done1), 32'h0);
      check("busy-req ENA c5", 32'(ena1), 32'h0);
      wait_idle();

      // Reset in the middle of the set phase
      pulse_req(TMP, MAR);
      repeat (5) @(negedge clk);
      check("mid-ST SET_DEC", 32'(set4), 32'h0100);
      #2 rst_n = 1'b0;
      #1;
      check("async rst ENA", 32'(ena4), 32'h0);
      check("async rst SET", 32'(set4), 32'h0);
      check("async rst BUSY", 32'(busy4), 32'h0);
      check("async rst READY", 32'(ready4), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("re-rst READY", 32'(ready4), 32'h1);
      check("re-rst DONE", 32'(done4), 32'h0);
      repeat (2) @(negedge clk);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
